// File: rtl/ex_flag_pkg.sv
// Shared types and helpers for the execute-stage flag back end:
// condition codes, NZCV bit positions and the branch-condition evaluator.
package ex_flag_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_HS = 4'd2,
    COND_LO = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic eval_cond(input cond_e cond, input logic [3:0] nzcv);
    logic n, z, c, v, res;
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    res = 1'b1;
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = ~z;
      COND_HS: res = c;
      COND_LO: res = ~c;
      COND_MI: res = n;
      COND_PL: res = ~n;
      COND_VS: res = v;
      COND_VC: res = ~v;
      COND_HI: res = c & ~z;
      COND_LS: res = ~c | z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = ~z & (n == v);
      COND_LE: res = z | (n != v);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ex_flag_stage_skid_buf.sv
// Two-entry ready/valid buffer with flush. The head entry is its own register,
// so the output data holds its last value when the buffer drains empty.
module ex_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data
);

  logic [DATA_W-1:0] head_q, spill_q;
  logic              head_vld_q, spill_vld_q;
  logic              push, pop;

  // spill is only ever occupied behind a valid head, so "spill free" means count < 2
  assign push_ready = ~spill_vld_q;
  assign pop_valid  = head_vld_q;
  assign pop_data   = head_q;

  assign push = push_valid & push_ready & ~flush;
  assign pop  = head_vld_q & pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      spill_q     <= '0;
      head_vld_q  <= 1'b0;
      spill_vld_q <= 1'b0;
    end else if (flush) begin
      head_vld_q  <= 1'b0;
      spill_vld_q <= 1'b0;
    end else if (pop) begin
      if (spill_vld_q) begin
        head_q      <= spill_q;
        spill_vld_q <= push;
        if (push) spill_q <= push_data;
      end else begin
        head_vld_q <= push;
        if (push) head_q <= push_data;
      end
    end else if (push) begin
      if (head_vld_q) begin
        spill_q     <= push_data;
        spill_vld_q <= 1'b1;
      end else begin
        head_q     <= push_data;
        head_vld_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_flag_stage.sv
// Execute-stage back end: derives NZCV from the adder outputs, keeps the
// architectural flag register, resolves branch conditions and buffers results.
module ex_flag_stage
  import ex_flag_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_sum,
  input  logic              in_overflow,
  input  logic              in_carry,
  input  logic              in_set_flags,
  input  logic              in_cond_check,
  input  logic [3:0]        in_cond,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_reg_write,
  output logic              out_cond_true,
  output logic [3:0]        flags
);

  localparam int BUF_W = WIDTH + DEST_W + 2;

  logic [3:0]       flags_q;
  logic [3:0]       new_nzcv;
  logic             accept;
  logic             cond_true;
  logic [BUF_W-1:0] push_data, pop_data;

  assign accept = in_valid & in_ready & ~flush;

  always_comb begin
    new_nzcv         = 4'b0000;
    new_nzcv[FLAG_N] = in_sum[WIDTH-1];
    new_nzcv[FLAG_Z] = (in_sum == '0);
    new_nzcv[FLAG_C] = in_carry;
    new_nzcv[FLAG_V] = in_overflow;
  end

  // Evaluated against the pre-accept flag value, so an op never sees its own flags.
  assign cond_true = in_cond_check ? eval_cond(cond_e'(in_cond), flags_q) : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (accept && in_set_flags) begin
      flags_q <= new_nzcv;
    end
  end

  assign flags     = flags_q;
  assign push_data = {in_sum, in_dest, in_reg_write, cond_true};

  ex_skid_buf #(
    .DATA_W(BUF_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push_valid(in_valid),
    .push_ready(in_ready),
    .push_data (push_data),
    .pop_valid (out_valid),
    .pop_ready (out_ready),
    .pop_data  (pop_data)
  );

  assign {out_result, out_dest, out_reg_write, out_cond_true} = pop_data;

endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed self-checking bench for ex_flag_stage: flags, conditions,
// backpressure ordering, flush and asynchronous reset.
module tb_ex_flag_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_sum;
  logic        in_overflow;
  logic        in_carry;
  logic        in_set_flags;
  logic        in_cond_check;
  logic [3:0]  in_cond;
  logic [4:0]  in_dest;
  logic        in_reg_write;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_dest;
  logic        out_reg_write;
  logic        out_cond_true;
  logic [3:0]  flags;

  int total = 0;
  int bad   = 0;

  ex_flag_stage #(.WIDTH(64), .DEST_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_overflow  (in_overflow),
    .in_carry     (in_carry),
    .in_set_flags (in_set_flags),
    .in_cond_check(in_cond_check),
    .in_cond      (in_cond),
    .in_dest      (in_dest),
    .in_reg_write (in_reg_write),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_dest     (out_dest),
    .out_reg_write(out_reg_write),
    .out_cond_true(out_cond_true),
    .flags        (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] sum, input logic c, input logic v,
                       input logic setf, input logic cchk, input logic [3:0] cond,
                       input logic [4:0] dest);
    in_valid      = 1'b1;
    in_sum        = sum;
    in_carry      = c;
    in_overflow   = v;
    in_set_flags  = setf;
    in_cond_check = cchk;
    in_cond       = cond;
    in_dest       = dest;
    in_reg_write  = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_sum = '0; in_overflow = 1'b0; in_carry = 1'b0;
    in_set_flags = 1'b0; in_cond_check = 1'b0; in_cond = 4'd0;
    in_dest = '0; in_reg_write = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    chk("rst_flags", 64'(flags), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_out_result", out_result, 64'h0);

    // zero sum with carry: Z and C set
    drive(64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 5'd3);
    tick();
    in_valid = 1'b0;
    chk("set_flags_0110", 64'(flags), 64'h6);
    chk("set_out_valid", 64'(out_valid), 64'h1);
    chk("set_out_result", out_result, 64'h0);
    chk("set_out_dest", 64'(out_dest), 64'd3);
    chk("set_nocheck_true", 64'(out_cond_true), 64'h1);
    tick();
    chk("set_popped", 64'(out_valid), 64'h0);

    // negative with overflow: N and V set
    drive(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 5'd4);
    tick();
    chk("neg_flags_1001", 64'(flags), 64'h9);
    chk("neg_out_result", out_result, 64'h8000_0000_0000_0000);
    drive(64'd7, 1'b0, 1'b0, 1'b0, 1'b1, 4'd12, 5'd5);
    tick();
    // GT holds here: Z clear and N==V
    chk("cond_gt", 64'(out_cond_true), 64'h1);
    chk("gt_result", out_result, 64'd7);
    drive(64'd8, 1'b0, 1'b0, 1'b0, 1'b1, 4'd11, 5'd5);
    tick();
    chk("cond_lt", 64'(out_cond_true), 64'h0);
    drive(64'd9, 1'b0, 1'b0, 1'b0, 1'b1, 4'd13, 5'd5);
    tick();
    chk("cond_le", 64'(out_cond_true), 64'h0);
    drive(64'd10, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 5'd5);
    tick();
    chk("cond_hi", 64'(out_cond_true), 64'h0);
    drive(64'd11, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 5'd5);
    tick();
    chk("cond_mi", 64'(out_cond_true), 64'h1);
    chk("flags_held_1001", 64'(flags), 64'h9);

    // own-flags exclusion
    drive(64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 5'd6);
    tick();
    chk("own_pre_0100", 64'(flags), 64'h4);
    drive(64'd5, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 5'd6);
    tick();
    chk("own_eq_old_z", 64'(out_cond_true), 64'h1);
    chk("own_flags_0000", 64'(flags), 64'h0);
    drive(64'd6, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 5'd6);
    tick();
    chk("eq_after_clear", 64'(out_cond_true), 64'h0);
    drive(64'd6, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 5'd6);
    tick();
    chk("cond_nv_always", 64'(out_cond_true), 64'h1);
    in_valid = 1'b0;
    tick();
    chk("own_drained", 64'(out_valid), 64'h0);

    // backpressure: A, B accepted, C stalls
    out_ready = 1'b0;
    drive(64'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd10);
    tick();
    drive(64'hBBBB, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd11);
    chk("bp_ready_one", 64'(in_ready), 64'h1);
    tick();
    drive(64'hCCCC, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd12);
    chk("bp_ready_full", 64'(in_ready), 64'h0);
    tick();
    chk("bp_still_full", 64'(in_ready), 64'h0);
    chk("bp_head_a", out_result, 64'hAAAA);
    out_ready = 1'b1;
    chk("bp_ready_indep", 64'(in_ready), 64'h0);
    tick();
    chk("bp_head_b", out_result, 64'hBBBB);
    chk("bp_dest_b", 64'(out_dest), 64'd11);
    chk("bp_ready_free", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    chk("bp_head_c", out_result, 64'hCCCC);
    chk("bp_valid_c", 64'(out_valid), 64'h1);
    tick();
    chk("bp_empty", 64'(out_valid), 64'h0);
    chk("bp_hold_c", out_result, 64'hCCCC);

    // flush with two entries buffered; committed flags survive
    out_ready = 1'b0;
    drive(64'h8000_0000_0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 5'd1);
    tick();
    drive(64'h22, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd2);
    tick();
    chk("fl_pre_flags", 64'(flags), 64'h8);
    chk("fl_pre_full", 64'(in_ready), 64'h0);
    drive(64'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 5'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'h0);
    chk("fl_in_ready", 64'(in_ready), 64'h1);
    chk("fl_flags_kept", 64'(flags), 64'h8);
    out_ready = 1'b1;
    tick();
    chk("fl_nothing_left", 64'(out_valid), 64'h0);

    // asynchronous reset mid-cycle with two entries buffered
    out_ready = 1'b0;
    drive(64'h11, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd7);
    tick();
    drive(64'h12, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd8);
    tick();
    in_valid = 1'b0;
    chk("ar_pre_valid", 64'(out_valid), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid_low", 64'(out_valid), 64'h0);
    chk("ar_flags", 64'(flags), 64'h0);
    chk("ar_result", out_result, 64'h0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(64'h33, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd9);
    tick();
    in_valid = 1'b0;
    chk("ar_new_entry", out_result, 64'h33);
    chk("ar_new_valid", 64'(out_valid), 64'h1);
    tick();
    chk("ar_count_zero", 64'(out_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
